// File: rtl/intctl_pkg.sv
// Shared state encodings and control-code constants for the interrupt sequencer
// and its decode/hazard consumers.
package intctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_PUSH_PC    = 3'd2,
    ST_PUSH_FLAGS = 3'd3,
    ST_JUMP       = 3'd4,
    ST_ISR        = 3'd5
  } state_t;

  localparam logic [3:0] CTRL_IDLE       = 4'b0000;
  localparam logic [3:0] CTRL_DRAIN      = 4'b0001;
  localparam logic [3:0] CTRL_PUSH_PC    = 4'b0011;
  localparam logic [3:0] CTRL_PUSH_FLAGS = 4'b0111;
  localparam logic [3:0] CTRL_JUMP       = 4'b1000;

  // ISR shares the idle code: the core runs normally inside the handler.
  function automatic logic [3:0] ctrl_code(input state_t s);
    case (s)
      ST_DRAIN:      ctrl_code = CTRL_DRAIN;
      ST_PUSH_PC:    ctrl_code = CTRL_PUSH_PC;
      ST_PUSH_FLAGS: ctrl_code = CTRL_PUSH_FLAGS;
      ST_JUMP:       ctrl_code = CTRL_JUMP;
      default:       ctrl_code = CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and
// the index of the lowest one.
module irq_priority_enc #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan downward so the last assignment is the lowest set index.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/multi_interrupt_control.sv
// Multi-channel interrupt entry sequencer: edge-captures requests, picks the
// lowest eligible channel and steps drain/push/jump/ISR with registered outputs.
module multi_interrupt_control
  import intctl_pkg::*;
#(
  parameter int N_IRQ     = 4,
  parameter int DRAIN_CYC = 3,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             stall,
  input  logic             rti,
  output logic [3:0]       ctrl_out,
  output logic [IDX_W-1:0] vec_id,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             busy
);

  localparam int                 CNT_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [N_IRQ-1:0]   ACK_ONE  = N_IRQ'(1);

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] rise_edge;
  logic [N_IRQ-1:0] eligible;
  logic             primed;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // primed masks the first post-reset cycle so lines already high at release
  // are not mistaken for new requests.
  assign rise_edge = irq_in & ~irq_q & {N_IRQ{primed}};
  assign eligible  = pending & ~irq_mask;

  irq_priority_enc #(
    .N_REQ (N_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // A new edge wins over a coincident acknowledge so no request is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q   <= '0;
      pending <= '0;
      primed  <= 1'b0;
    end else begin
      irq_q   <= irq_in;
      primed  <= 1'b1;
      pending <= (pending & ~irq_ack) | rise_edge;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ctrl_out <= CTRL_IDLE;
      vec_id   <= '0;
      irq_ack  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!stall && win_valid) begin
            state    <= ST_DRAIN;
            cnt      <= '0;
            vec_id   <= win_idx;
            ctrl_out <= ctrl_code(ST_DRAIN);
            busy     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!stall) begin
            if (cnt == CNT_LAST) begin
              state    <= ST_PUSH_PC;
              ctrl_out <= ctrl_code(ST_PUSH_PC);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_PUSH_PC: begin
          if (!stall) begin
            state    <= ST_PUSH_FLAGS;
            ctrl_out <= ctrl_code(ST_PUSH_FLAGS);
          end
        end
        ST_PUSH_FLAGS: begin
          if (!stall) begin
            state    <= ST_JUMP;
            ctrl_out <= ctrl_code(ST_JUMP);
            irq_ack  <= ACK_ONE << vec_id;
          end
        end
        ST_JUMP: begin
          if (!stall) begin
            state    <= ST_ISR;
            ctrl_out <= ctrl_code(ST_ISR);
            irq_ack  <= '0;
          end
        end
        ST_ISR: begin
          // Return is honoured even under stall so the handler can always exit.
          if (rti) begin
            state    <= ST_IDLE;
            ctrl_out <= ctrl_code(ST_IDLE);
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ctrl_out <= CTRL_IDLE;
          irq_ack  <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_interrupt_control.sv
// Directed bench for multi_interrupt_control: reset, single request, priority,
// masking, stall, mid-sequence reset and no-nesting behaviour.
module tb_multi_interrupt_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irq_in = '0;
  logic [3:0] irq_mask = '0;
  logic       stall = 1'b0;
  logic       rti = 1'b0;
  logic [3:0] ctrl_out;
  logic [1:0] vec_id;
  logic [3:0] irq_ack;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_interrupt_control #(
    .N_IRQ     (4),
    .DRAIN_CYC (3),
    .IDX_W     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .irq_mask (irq_mask),
    .stall    (stall),
    .rti      (rti),
    .ctrl_out (ctrl_out),
    .vec_id   (vec_id),
    .irq_ack  (irq_ack),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (ctrl_out == 4'b0001) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    irq_in = 4'b0001;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (ctrl_out !== 4'b0000 || vec_id !== 2'd0 || irq_ack !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ctrl=%b vec=%0d ack=%b busy=%b, required 0000/0/0000/0",
               ctrl_out, vec_id, irq_ack, busy);
    end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || ctrl_out !== 4'b0000) begin
        errors++;
        $display("FAIL release_high_line cyc %0d: busy=%b ctrl=%b, required busy=0 ctrl=0000",
                 k, busy, ctrl_out);
      end
    end
    irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] exp_ctrl [6];
    bit found;
    exp_ctrl = '{4'b0001, 4'b0001, 4'b0011, 4'b0111, 4'b1000, 4'b0000};
    irq_in = 4'b0001;
    wait_drain(4, found);
    checks++;
    if (!found || vec_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start: found=%0d vec=%0d busy=%b, required found=1 vec=0 busy=1",
               found, vec_id, busy);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (ctrl_out !== exp_ctrl[k] || vec_id !== 2'd0 || busy !== 1'b1 ||
          irq_ack !== ((k == 4) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL single_seq step %0d: ctrl=%b vec=%0d ack=%b busy=%b, required ctrl=%b vec=0 ack=%b busy=1",
                 k, ctrl_out, vec_id, irq_ack, busy, exp_ctrl[k], (k == 4) ? 4'b0001 : 4'b0000);
      end
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || ctrl_out !== 4'b0000) begin
      errors++;
      $display("FAIL single_isr_hold: busy=%b ctrl=%b, required busy=1 ctrl=0000", busy, ctrl_out);
    end
    rti = 1'b1;
    tick();
    rti = 1'b0;
    checks++;
    if (busy !== 1'b0 || ctrl_out !== 4'b0000) begin
      errors++;
      $display("FAIL single_rti: busy=%b ctrl=%b, required busy=0 ctrl=0000", busy, ctrl_out);
    end
    irq_in = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_priority();
    logic [3:0] exp_ctrl [6];
    bit found;
    exp_ctrl = '{4'b0001, 4'b0001, 4'b0011, 4'b0111, 4'b1000, 4'b0000};
    irq_in = 4'b0110;
    wait_drain(4, found);
    checks++;
    if (!found || vec_id !== 2'd1) begin
      errors++;
      $display("FAIL prio_first: found=%0d vec=%0d, required found=1 vec=1", found, vec_id);
    end
    // rti pulsed during DRAIN must be ignored
    for (int k = 0; k < 6; k++) begin
      if (k == 0) rti = 1'b1;
      tick();
      rti = 1'b0;
      checks++;
      if (ctrl_out !== exp_ctrl[k] || vec_id !== 2'd1 || busy !== 1'b1 ||
          irq_ack !== ((k == 4) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL prio_seq1 step %0d: ctrl=%b vec=%0d ack=%b busy=%b, required ctrl=%b vec=1 ack=%b busy=1",
                 k, ctrl_out, vec_id, irq_ack, busy, exp_ctrl[k], (k == 4) ? 4'b0010 : 4'b0000);
      end
    end
    rti = 1'b1;
    tick();
    rti = 1'b0;
    checks++;
    if (busy !== 1'b0 || ctrl_out !== 4'b0000) begin
      errors++;
      $display("FAIL prio_idle_gap: busy=%b ctrl=%b, required busy=0 ctrl=0000", busy, ctrl_out);
    end
    tick();
    checks++;
    if (ctrl_out !== 4'b0001 || vec_id !== 2'd2) begin
      errors++;
      $display("FAIL prio_second: ctrl=%b vec=%0d, required ctrl=0001 vec=2", ctrl_out, vec_id);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (ctrl_out !== exp_ctrl[k] || vec_id !== 2'd2 ||
          irq_ack !== ((k == 4) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL prio_seq2 step %0d: ctrl=%b vec=%0d ack=%b, required ctrl=%b vec=2 ack=%b",
                 k, ctrl_out, vec_id, irq_ack, exp_ctrl[k], (k == 4) ? 4'b0100 : 4'b0000);
      end
    end
    rti = 1'b1;
    tick();
    rti = 1'b0;
    irq_in = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_drained: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_mask();
    bit found;
    irq_mask = 4'b0001;
    irq_in   = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || ctrl_out !== 4'b0000) begin
        errors++;
        $display("FAIL mask_hold cyc %0d: busy=%b ctrl=%b, required busy=0 ctrl=0000", k, busy, ctrl_out);
      end
    end
    irq_mask = 4'b0000;
    wait_drain(2, found);
    checks++;
    if (!found || vec_id !== 2'd0) begin
      errors++;
      $display("FAIL mask_release: found=%0d vec=%0d, required found=1 vec=0", found, vec_id);
    end
    for (int k = 0; k < 6; k++) tick();
    rti = 1'b1;
    tick();
    rti = 1'b0;
    irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_stall();
    logic [3:0] exp_ctrl [10];
    bit found;
    exp_ctrl = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                 4'b0011, 4'b0111, 4'b1000, 4'b0000};
    irq_in = 4'b0001;
    wait_drain(4, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_start: found=%0d, required 1", found);
    end
    // step 0 lands on the second DRAIN cycle; stall spans the next four edges
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) stall = 1'b1;
      if (k == 4) stall = 1'b0;
      checks++;
      if (ctrl_out !== exp_ctrl[k] || vec_id !== 2'd0 ||
          irq_ack !== ((k == 8) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL stall_seq step %0d: ctrl=%b vec=%0d ack=%b, required ctrl=%b vec=0 ack=%b",
                 k, ctrl_out, vec_id, irq_ack, exp_ctrl[k], (k == 8) ? 4'b0001 : 4'b0000);
      end
    end
    rti = 1'b1;
    tick();
    rti = 1'b0;
    irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    bit found;
    bit acked;
    irq_in = 4'b0010;
    wait_drain(4, found);
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (!found || ctrl_out !== 4'b0111) begin
      errors++;
      $display("FAIL rstmid_reach: found=%0d ctrl=%b, required found=1 ctrl=0111", found, ctrl_out);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ctrl_out !== 4'b0000 || busy !== 1'b0 || irq_ack !== 4'b0000 || vec_id !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_async: ctrl=%b busy=%b ack=%b vec=%0d, required 0000/0/0000/0",
               ctrl_out, busy, irq_ack, vec_id);
    end
    tick();
    rst = 1'b1;
    acked = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (irq_ack !== 4'b0000 || busy !== 1'b0) acked = 1'b1;
    end
    checks++;
    if (acked) begin
      errors++;
      $display("FAIL rstmid_pending_cleared: activity=%0d, required 0", acked);
    end
    irq_in = 4'b0000;
    tick();
  endtask

  task automatic test_nesting();
    logic [3:0] exp_ctrl [6];
    bit found;
    exp_ctrl = '{4'b0001, 4'b0001, 4'b0011, 4'b0111, 4'b1000, 4'b0000};
    irq_in = 4'b0001;
    wait_drain(4, found);
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (!found || ctrl_out !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nest_in_isr: found=%0d ctrl=%b busy=%b, required 1/0000/1", found, ctrl_out, busy);
    end
    irq_in = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ctrl_out !== 4'b0000 || busy !== 1'b1 || vec_id !== 2'd0) begin
        errors++;
        $display("FAIL nest_hold cyc %0d: ctrl=%b busy=%b vec=%0d, required 0000/1/0", k, ctrl_out, busy, vec_id);
      end
    end
    rti = 1'b1;
    tick();
    rti = 1'b0;
    checks++;
    if (busy !== 1'b0 || ctrl_out !== 4'b0000) begin
      errors++;
      $display("FAIL nest_idle_gap: busy=%b ctrl=%b, required busy=0 ctrl=0000", busy, ctrl_out);
    end
    tick();
    checks++;
    if (ctrl_out !== 4'b0001 || vec_id !== 2'd3) begin
      errors++;
      $display("FAIL nest_second: ctrl=%b vec=%0d, required ctrl=0001 vec=3", ctrl_out, vec_id);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (ctrl_out !== exp_ctrl[k] || vec_id !== 2'd3 ||
          irq_ack !== ((k == 4) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL nest_seq step %0d: ctrl=%b vec=%0d ack=%b, required ctrl=%b vec=3 ack=%b",
                 k, ctrl_out, vec_id, irq_ack, exp_ctrl[k], (k == 4) ? 4'b1000 : 4'b0000);
      end
    end
    rti = 1'b1;
    tick();
    rti = 1'b0;
    irq_in = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_stall();
    test_reset_mid();
    test_nesting();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
